// File: rtl/arch_reg_debug_port.sv
// Debug responder: reads committed architectural registers through the rename map and PRF.
// Optional running XOR checksum of sweep data enabled by defining ARD_CHECKSUM_EN.
module arch_reg_debug_port #(
  parameter int ARCH_REGS = 32,
  parameter int AREG_W    = 5,
  parameter int PREG_W    = 7,
  parameter int XLEN      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AREG_W-1:0] req_areg,
  input  logic              req_all,
  output logic              stall_commit,
  output logic              map_rd_en,
  output logic [AREG_W-1:0] map_rd_areg,
  input  logic [PREG_W-1:0] map_rd_preg,
  output logic              prf_rd_en,
  output logic [PREG_W-1:0] prf_rd_addr,
  input  logic [XLEN-1:0]   prf_rd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [AREG_W-1:0] resp_areg,
  output logic [PREG_W-1:0] resp_preg,
  output logic [XLEN-1:0]   resp_data,
  output logic              resp_last,
  output logic [XLEN-1:0]   resp_checksum
);

  typedef enum logic [1:0] {S_IDLE, S_MAP, S_PRF, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [AREG_W-1:0] areg_q;
  logic              all_q;
  logic              first_q;
  logic [PREG_W-1:0] preg_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   data_cur;
  logic              accept;
  logic              resp_hs;
  logic              is_last;

  assign accept  = (state_q == S_IDLE) && req_valid;
  assign resp_hs = (state_q == S_RESP) && resp_ready;
  assign is_last = !all_q || (areg_q == AREG_W'(ARCH_REGS - 1));

  // PRF data is only valid in the first RESP cycle; afterwards the captured copy is shown.
  assign data_cur = first_q ? ((areg_q == '0) ? '0 : prf_rd_data) : data_q;

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    stall_commit = 1'b1;
    map_rd_en    = 1'b0;
    map_rd_areg  = '0;
    prf_rd_en    = 1'b0;
    prf_rd_addr  = '0;
    resp_valid   = 1'b0;
    resp_areg    = '0;
    resp_preg    = '0;
    resp_data    = '0;
    resp_last    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready    = 1'b1;
        stall_commit = 1'b0;
        if (req_valid) state_d = S_MAP;
      end
      S_MAP: begin
        map_rd_en   = 1'b1;
        map_rd_areg = areg_q;
        state_d     = S_PRF;
      end
      S_PRF: begin
        prf_rd_en   = 1'b1;
        prf_rd_addr = map_rd_preg;
        state_d     = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_areg  = areg_q;
        resp_preg  = preg_q;
        resp_data  = data_cur;
        resp_last  = is_last;
        if (resp_ready) state_d = is_last ? S_IDLE : S_MAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      areg_q  <= '0;
      all_q   <= 1'b0;
      first_q <= 1'b0;
      preg_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        areg_q <= req_all ? '0 : req_areg;
        all_q  <= req_all;
      end else if (resp_hs && !is_last) begin
        areg_q <= areg_q + AREG_W'(1);
      end
      if (state_q == S_PRF) preg_q <= map_rd_preg;
      first_q <= (state_q == S_PRF);
      if (first_q) data_q <= data_cur;
    end
  end

`ifdef ARD_CHECKSUM_EN
  logic [XLEN-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (!reset)       csum_q <= '0;
    else if (accept)  csum_q <= '0;
    else if (resp_hs) csum_q <= csum_q ^ data_cur;
  end

  assign resp_checksum = (state_q == S_RESP) ? (csum_q ^ data_cur) : '0;
`else
  assign resp_checksum = '0;
`endif

endmodule

// File: tb/tb_arch_reg_debug_port.sv
// Directed bench for arch_reg_debug_port with behavioural map/PRF memories (1-cycle read latency).
module tb_arch_reg_debug_port;

  localparam int AREG_W = 5;
  localparam int PREG_W = 7;
  localparam int XLEN   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [AREG_W-1:0] req_areg;
  logic              req_all;
  logic              stall_commit;
  logic              map_rd_en;
  logic [AREG_W-1:0] map_rd_areg;
  logic [PREG_W-1:0] map_rd_preg;
  logic              prf_rd_en;
  logic [PREG_W-1:0] prf_rd_addr;
  logic [XLEN-1:0]   prf_rd_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [AREG_W-1:0] resp_areg;
  logic [PREG_W-1:0] resp_preg;
  logic [XLEN-1:0]   resp_data;
  logic              resp_last;
  logic [XLEN-1:0]   resp_checksum;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  arch_reg_debug_port #(
    .ARCH_REGS(32),
    .AREG_W   (AREG_W),
    .PREG_W   (PREG_W),
    .XLEN     (XLEN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_areg     (req_areg),
    .req_all      (req_all),
    .stall_commit (stall_commit),
    .map_rd_en    (map_rd_en),
    .map_rd_areg  (map_rd_areg),
    .map_rd_preg  (map_rd_preg),
    .prf_rd_en    (prf_rd_en),
    .prf_rd_addr  (prf_rd_addr),
    .prf_rd_data  (prf_rd_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_areg    (resp_areg),
    .resp_preg    (resp_preg),
    .resp_data    (resp_data),
    .resp_last    (resp_last),
    .resp_checksum(resp_checksum)
  );

  logic [PREG_W-1:0] map_mem [32];
  logic [XLEN-1:0]   phy_mem [128];

  // Read data is garbage unless the strobe was high the cycle before.
  always @(posedge clk) begin
    map_rd_preg <= map_rd_en ? map_mem[map_rd_areg] : 7'h7F;
    prf_rd_data <= prf_rd_en ? phy_mem[prf_rd_addr] : 32'hBAD0_0BAD;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic issue(input logic [AREG_W-1:0] a, input logic all);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_areg  = a;
    req_all   = all;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_all   = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic single_read(input logic [AREG_W-1:0] a, output logic [PREG_W-1:0] p,
                             output logic [XLEN-1:0] d, output logic l, output int lat);
    resp_ready = 1'b1;
    issue(a, 1'b0);
    wait_resp(lat);
    p = resp_preg;
    d = resp_data;
    l = resp_last;
    @(negedge clk);
  endtask

  task automatic sweep(input int mode, input logic bp);
    int idx = 0;
    int cyc = 0;
    int stall_bad = 0;
    logic held = 1'b0;
    logic [XLEN-1:0] hold_d = '0;
    logic [XLEN-1:0] exp;
    logic [XLEN-1:0] cks = '0;
    resp_ready = 1'b1;
    issue(5'd17, 1'b1);
    while (idx < 32 && cyc < 400) begin
      resp_ready = bp ? (cyc % 2 == 1) : 1'b1;
      if (!stall_commit || req_ready) stall_bad++;
      if (held) begin
        chk("resp_withdrawn", 32'(resp_valid), 1);
        chk("resp_hold_data", resp_data, hold_d);
      end
      if (resp_valid) begin
        if (resp_ready) begin
          exp = (idx == 0) ? 32'd0 : ((mode == 0) ? 32'(idx * 3) : (32'd1 << idx));
          cks = cks ^ exp;
          chk("sweep_areg", 32'(resp_areg), 32'(idx));
          chk("sweep_data", resp_data, exp);
          chk("sweep_last", 32'(resp_last), 32'(idx == 31));
          if (idx == 31) begin
`ifdef ARD_CHECKSUM_EN
            chk("sweep_checksum", resp_checksum, cks);
`else
            chk("sweep_checksum", resp_checksum, 32'd0);
`endif
          end
          idx++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          hold_d = resp_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("sweep_count", 32'(idx), 32);
    chk("sweep_stall_req", 32'(stall_bad), 0);
    chk("post_sweep_idle", {29'd0, stall_commit, req_ready, resp_valid}, 32'b010);
    if (mode == 1) begin
`ifdef ARD_CHECKSUM_EN
      chk("t6_checksum_const", cks, 32'hFFFF_FFFE);
`endif
    end
  endtask

  typedef struct {
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [XLEN-1:0]   data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [PREG_W-1:0] p;
    logic [XLEN-1:0]   d;
    logic              l;
    int                lat;
    int                n;

    for (int i = 0; i < 32; i++) map_mem[i] = 7'(i + 40);
    map_mem[0]  = 7'd0;
    map_mem[10] = 7'd7;
    for (int i = 0; i < 128; i++) phy_mem[i] = 32'hA000_0000 | 32'(i * 273);
    phy_mem[7] = 32'h0000_002A;
    phy_mem[0] = 32'hDEAD_BEEF;

    vecs[0] = '{areg: 5'd10, preg: 7'd7,  data: 32'h0000_002A};
    vecs[1] = '{areg: 5'd0,  preg: 7'd0,  data: 32'h0000_0000};
    vecs[2] = '{areg: 5'd31, preg: 7'd71, data: 32'hA000_4BB7};
    vecs[3] = '{areg: 5'd1,  preg: 7'd41, data: 32'hA000_2BB9};
    vecs[4] = '{areg: 5'd5,  preg: 7'd45, data: 32'hA000_2FFD};

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_areg   = '0;
    req_all    = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {26'd0, req_ready, stall_commit, map_rd_en, prf_rd_en, resp_valid, resp_last},
        32'b100000);
    chk("reset_data", resp_data | resp_checksum | 32'(resp_preg) | 32'(resp_areg), 0);
    reset = 1'b1;

    // T1/T2 and extra single reads
    for (int i = 0; i < 5; i++) begin
      single_read(vecs[i].areg, p, d, l, lat);
      chk("single_latency", 32'(lat), 3);
      chk("single_preg", 32'(p), 32'(vecs[i].preg));
      chk("single_data", d, vecs[i].data);
      chk("single_last", 32'(l), 1);
    end

    // T4: request held during a single read
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_areg  = 5'd10;
    req_all   = 1'b0;
    chk("t4_first_ready", 32'(req_ready), 1);
    @(negedge clk);
    wait_resp(lat);
    chk("t4_latency", 32'(lat), 3);
    chk("t4_busy_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("t4_ready_after", 32'(req_ready), 1);
    chk("t4_no_resp", 32'(resp_valid), 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t4_second_accepted", 32'(stall_commit), 1);
    wait_resp(lat);
    chk("t4_second_latency", 32'(lat), 3);
    chk("t4_second_data", resp_data, 32'h0000_002A);
    @(negedge clk);

    // T3: sweep, phy[map[i]] = i*3, backpressure
    map_mem[10] = 7'd50;
    for (int i = 1; i < 32; i++) phy_mem[i + 40] = 32'(i * 3);
    sweep(0, 1'b1);

    // T6: sweep, phy[map[i]] = 1<<i, no backpressure
    for (int i = 1; i < 32; i++) phy_mem[i + 40] = 32'd1 << i;
    phy_mem[0] = 32'd1;
    sweep(1, 1'b0);

    // T5: reset while in RESP at areg 12
    resp_ready = 1'b1;
    issue(5'd0, 1'b1);
    n = 0;
    while (!(resp_valid && resp_areg == 5'd12) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach12", 32'(n < 200), 1);
    resp_ready = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    chk("t5_after_reset", {29'd0, resp_valid, stall_commit, req_ready}, 32'b001);
    reset = 1'b1;
    single_read(5'd5, p, d, l, lat);
    chk("t5_latency", 32'(lat), 3);
    chk("t5_preg", 32'(p), 45);
    chk("t5_data", d, 32'h0000_0020);
    chk("t5_last", 32'(l), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
